nibble_serial_sub: RTL and testbench
====================================

# nibble_serial_sub

- Multi-cycle WIDTH-bit subtractor: computes a − b − bin one 4-bit nibble per clock.
- Reuses the existing 4-bit carry-lookahead adder slice, fed inverted b and an inverted borrow-in.
- Is the subtraction-side companion of that adder, for datapaths where area matters more than latency.
- Sits between a valid/ready producer and consumer and holds its result until taken.

## Interface
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and ≥ 4.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- diff  output  WIDTH  a − b − bin modulo 2^WIDTH.
- bout  output  1  borrow-out: 1 when unsigned a < b + bin.
- ovf  output  1  signed (two's-complement) overflow of the subtraction.

## Operation
- NIB = WIDTH/4.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: latch a, ~b and carry=~bin; clear the nibble index k; go to BUSY.
- BUSY:
  - in_ready=0; a, b, bin and in_valid are ignored.
  - Each cycle the slice adds a[4k+3:4k] + ~b[4k+3:4k] + carry.
  - The 4-bit sum is written into nibble k of an internal work register; carry takes the slice cout; k increments.
  - After nibble NIB−1 is processed, load the output registers and go to DONE:
    - diff = work register.
    - bout = ~final carry.
    - ovf = (a[MSB] ≠ b[MSB]) & (diff[MSB] ≠ a[MSB]).
- DONE:
  - out_valid=1; diff, bout and ovf are held stable.
  - On out_ready go to IDLE. Without out_ready, stay in DONE indefinitely.
- diff, bout and ovf change only on entry to DONE or on reset. Outside DONE they keep the last result and must not be interpreted.
- Arithmetic:
  - Internal carry is 1 bit; wrap-around modulo 2^WIDTH.
  - bin=1 with a=b gives diff = all-ones, bout=1.

## Timing
- Reset (any state, including mid-BUSY or DONE):
  - Next edge gives state=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, ovf=0, k=0.
  - An in-flight operation is discarded with no result.
- Latency: the operands are accepted on edge T. out_valid is high after edge T+NIB (for WIDTH=4, the cycle after acceptance).
- Throughput:
  - No overlap between operations; in_ready stays low from the accepting edge until DONE exits.
  - With out_ready held high, the next accept is at edge T+NIB+2 at the earliest.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - out_ready while out_valid=0 has no effect.
  - in_valid in the same cycle that DONE exits is not accepted; in_ready rises the following cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared arithmetic package holds:
  - the state enum (IDLE/BUSY/DONE);
  - the nibble width constant (4);
  - a helper giving NIB from WIDTH.
- One sub-module: the existing cla_4bit adder slice, instantiated once and time-multiplexed across nibbles, with no modification.
- Nibble select/insert is done with an indexed part-select on k.
- Elaboration-time check: WIDTH % 4 == 0.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234, bin=0 -> diff=0x1000, bout=0, ovf=0; out_valid exactly 4 cycles after accept.
- a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0; and a=0x8000, b=0x0001 -> diff=0x7FFF, bout=0, ovf=1.
- a=0x0005, b=0x0003, bin=1 -> diff=0x0001, bout=0; a=b=0x00FF, bin=1 -> diff=0xFFFF, bout=1.
- out_ready low for 5 cycles in DONE -> out_valid held with diff/bout/ovf unchanged and in_ready=0. Meanwhile toggle in_valid with new operands -> ignored, and the result still matches the first operands.
- Assert rst during BUSY at k=2 -> next cycle in_ready=1, out_valid=0, diff=0. A fresh a=0x0010, b=0x0001 then gives 0x000F.
- WIDTH=4 instance, all 512 combinations of a, b, bin, with random out_ready -> each diff/bout/ovf matches the reference model; out_valid one cycle after accept.

Source files
------------

// File: rtl/nibble_serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_sub_pkg
//  Description : Shared arithmetic definitions for the nibble-serial
//                subtractor: FSM state encoding, nibble width and the
//                helper that derives the nibble count from the operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package nibble_serial_sub_pkg;

    // Width of one arithmetic slice; the datapath is walked in steps of this.
    localparam int NIB_W = 4;

    // Control states of the serial subtractor.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Number of slice passes needed for an operand of the given width.
    function automatic int nib_count(input int width);
        return width / NIB_W;
    endfunction

endpackage : nibble_serial_sub_pkg
`default_nettype wire

// File: rtl/nibble_serial_sub_cla_4bit.sv
`default_nettype none
// ============================================================================
//  Module      : cla_4bit
//  Description : 4-bit carry-lookahead adder slice. Generate/propagate terms
//                feed flat lookahead equations so every carry is two gate
//                levels from the inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    // Flat lookahead carries, each expressed directly from g, p and cin.
    always_comb begin
        c[0] = cin_i;
        c[1] = g[0] | (p[0] & cin_i);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin_i);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin_i);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin_i);
    end

    assign sum_o  = p ^ c[3:0];
    assign cout_o = c[4];

endmodule : cla_4bit
`default_nettype wire

// File: rtl/nibble_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_sub
//  Description : Multi-cycle WIDTH-bit subtractor computing a - b - bin one
//                nibble per clock through a single shared 4-bit CLA slice.
//                Subtraction is done as a + ~b + ~bin; the final carry is the
//                inverted borrow. Valid/ready handshake on both sides, result
//                held in DONE until the consumer takes it.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_sub
    import nibble_serial_sub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             ovf
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int K_W   = (NIB > 1) ? $clog2(NIB) : 1;
    localparam int IDX_W = $clog2(WIDTH);
    localparam int MSB   = WIDTH - 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NIB - 1);

    // Reject widths the slice cannot tile exactly.
    generate
        if ((WIDTH % NIB_W) != 0 || WIDTH < NIB_W) begin : g_width_check
            $error("nibble_serial_sub: WIDTH must be a multiple of 4 and >= 4");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_e           state_q,     state_d;
    logic [K_W-1:0]   k_q,         k_d;
    logic [WIDTH-1:0] a_q,         a_d;
    logic [WIDTH-1:0] bn_q,        bn_d;      // subtrahend, stored inverted
    logic             carry_q,     carry_d;   // running carry = ~borrow
    logic [WIDTH-1:0] work_q,      work_d;
    logic [WIDTH-1:0] diff_q,      diff_d;
    logic             bout_q,      bout_d;
    logic             ovf_q,       ovf_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    // ------------------------------------------------------------------
    // Shared slice: nibble k of a and ~b plus the running carry
    // ------------------------------------------------------------------
    logic [IDX_W-1:0] nib_idx;
    logic [NIB_W-1:0] slice_a;
    logic [NIB_W-1:0] slice_b;
    logic [NIB_W-1:0] slice_sum;
    logic             slice_cout;

    assign nib_idx = IDX_W'(k_q) << $clog2(NIB_W);
    assign slice_a = a_q[nib_idx +: NIB_W];
    assign slice_b = bn_q[nib_idx +: NIB_W];

    cla_4bit u_cla (
        .a_i    (slice_a),
        .b_i    (slice_b),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
    );

    // State register and all datapath/output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            k_q         <= '0;
            a_q         <= '0;
            bn_q        <= '0;
            carry_q     <= 1'b0;
            work_q      <= '0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            a_q         <= a_d;
            bn_q        <= bn_d;
            carry_q     <= carry_d;
            work_q      <= work_d;
            diff_q      <= diff_d;
            bout_q      <= bout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, nibble sequencing and result capture.
    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        a_d      = a_q;
        bn_d     = bn_q;
        carry_d  = carry_q;
        work_d   = work_q;
        diff_d   = diff_q;
        bout_d   = bout_q;
        ovf_d    = ovf_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    bn_d    = ~b;
                    carry_d = ~bin;
                    k_d     = '0;
                    state_d = ST_BUSY;
                end
            end

            ST_BUSY: begin
                work_d[nib_idx +: NIB_W] = slice_sum;
                carry_d                  = slice_cout;
                if (k_q == K_LAST) begin
                    // Last nibble: work_d now holds the full difference.
                    k_d     = '0;
                    diff_d  = work_d;
                    bout_d  = ~slice_cout;
                    // Operand signs differ (b's sign is ~bn) and result sign
                    // departs from the minuend's sign.
                    ovf_d   = (a_q[MSB] ^ ~bn_q[MSB]) & (work_d[MSB] ^ a_q[MSB]);
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + K_W'(1);
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Handshake flags are registered copies of the upcoming state.
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;

endmodule : nibble_serial_sub
`default_nettype wire

// File: tb/tb_nibble_serial_sub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_sub
//  Description : Self-checking bench for nibble_serial_sub at WIDTH=16 and
//                WIDTH=4 against an integer-arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_sub;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    // WIDTH=16 instance
    logic        in_valid16 = 1'b0, out_ready16 = 1'b0, bin16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic        in_ready16, out_valid16, bout16, ovf16;
    logic [15:0] diff16;

    // WIDTH=4 instance
    logic        in_valid4 = 1'b0, out_ready4 = 1'b0, bin4 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic        in_ready4, out_valid4, bout4, ovf4;
    logic [3:0]  diff4;

    nibble_serial_sub #(.WIDTH(16)) u_dut16 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .bin(bin16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .diff(diff16), .bout(bout16), .ovf(ovf16)
    );

    nibble_serial_sub #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .a(a4), .b(b4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4),
        .diff(diff4), .bout(bout4), .ovf(ovf4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on unsigned and signed views.
    task automatic model(input int w, input logic [15:0] a, input logic [15:0] b,
                         input logic bin, output logic [15:0] d,
                         output logic bo, output logic ov);
        int ia, ib, ib2, r, half, sa, sb, sr, mask;
        ia   = int'(a);
        ib   = int'(b);
        ib2  = ib + int'(bin);
        mask = (1 << w) - 1;
        half = 1 << (w - 1);
        r    = ia - ib2;
        d    = 16'(r & mask);
        bo   = (ia < ib2);
        sa   = (ia >= half) ? ia - 2 * half : ia;
        sb   = (ib >= half) ? ib - 2 * half : ib;
        sr   = sa - sb - int'(bin);
        ov   = (sr < -half) || (sr > half - 1);
    endtask

    function automatic logic g_in_ready(input bit w4);
        return w4 ? in_ready4 : in_ready16;
    endfunction
    function automatic logic g_out_valid(input bit w4);
        return w4 ? out_valid4 : out_valid16;
    endfunction
    function automatic logic [15:0] g_diff(input bit w4);
        return w4 ? {12'h000, diff4} : diff16;
    endfunction
    function automatic logic g_bout(input bit w4);
        return w4 ? bout4 : bout16;
    endfunction
    function automatic logic g_ovf(input bit w4);
        return w4 ? ovf4 : ovf16;
    endfunction

    task automatic drive_in(input bit w4, input logic v, input logic [15:0] a,
                            input logic [15:0] b, input logic bin);
        if (w4) begin
            in_valid4 = v; a4 = a[3:0]; b4 = b[3:0]; bin4 = bin;
        end else begin
            in_valid16 = v; a16 = a; b16 = b; bin16 = bin;
        end
    endtask

    task automatic set_ready(input bit w4, input logic r);
        if (w4) out_ready4 = r;
        else    out_ready16 = r;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: accept, latency, result, hold in DONE, release.
    task automatic run_op(input bit w4, input logic [15:0] a, input logic [15:0] b,
                          input logic bin, input int hold, input bit noise);
        logic [15:0] ed;
        logic        ebo, eov;
        int          n;
        int          w;
        w = w4 ? 4 : 16;
        model(w, a, b, bin, ed, ebo, eov);

        n = 0;
        while (!g_in_ready(w4) && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_idle", 32'(g_in_ready(w4)), 32'd1);

        drive_in(w4, 1'b1, a, b, bin);
        // out_ready is irrelevant while out_valid is low
        set_ready(w4, 1'($urandom_range(0, 1)));
        tick();
        drive_in(w4, 1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        check("in_ready_busy", 32'(g_in_ready(w4)), 32'd0);

        n = 0;
        while (!g_out_valid(w4) && n < 40) begin
            set_ready(w4, 1'($urandom_range(0, 1)));
            tick();
            n++;
        end
        set_ready(w4, 1'b0);
        check("latency", 32'(n), 32'(w / 4));
        check("diff", 32'(g_diff(w4)), 32'(ed));
        check("bout", 32'(g_bout(w4)), 32'(ebo));
        check("ovf", 32'(g_ovf(w4)), 32'(eov));

        for (int i = 0; i < hold; i++) begin
            if (noise)
                drive_in(w4, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                         1'($urandom_range(0, 1)));
            tick();
            check("hold_valid", 32'(g_out_valid(w4)), 32'd1);
            check("hold_in_ready", 32'(g_in_ready(w4)), 32'd0);
            check("hold_diff", 32'(g_diff(w4)), 32'(ed));
            check("hold_flags", {30'd0, g_bout(w4), g_ovf(w4)}, {30'd0, ebo, eov});
        end

        // Exit DONE; in_valid high in the exit cycle must not be taken.
        if (noise) drive_in(w4, 1'b1, 16'($urandom), 16'($urandom), 1'b0);
        set_ready(w4, 1'b1);
        tick();
        set_ready(w4, 1'b0);
        drive_in(w4, 1'b0, 16'h0, 16'h0, 1'b0);
        check("exit_valid", 32'(g_out_valid(w4)), 32'd0);
        check("exit_in_ready", 32'(g_in_ready(w4)), 32'd1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
    } vec_t;

    initial begin
        vec_t dir [5];
        dir[0] = '{16'h1234, 16'h0234, 1'b0};
        dir[1] = '{16'h0000, 16'h0001, 1'b0};
        dir[2] = '{16'h8000, 16'h0001, 1'b0};
        dir[3] = '{16'h0005, 16'h0003, 1'b1};
        dir[4] = '{16'h00FF, 16'h00FF, 1'b1};

        // Reset state
        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready16", 32'(in_ready16), 32'd1);
        check("rst_out_valid16", 32'(out_valid16), 32'd0);
        check("rst_diff16", 32'(diff16), 32'd0);
        check("rst_flags16", {30'd0, bout16, ovf16}, 32'd0);
        check("rst_in_ready4", 32'(in_ready4), 32'd1);
        check("rst_out_valid4", 32'(out_valid4), 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases
        foreach (dir[i]) run_op(1'b0, dir[i].a, dir[i].b, dir[i].bin, 0, 1'b0);

        // Held result with operand noise while in DONE
        run_op(1'b0, 16'h4321, 16'h1111, 1'b0, 5, 1'b1);

        // Reset in the middle of BUSY (k=2)
        drive_in(1'b0, 1'b1, 16'hABCD, 16'h1234, 1'b0);
        tick();
        drive_in(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready16), 32'd1);
        check("midrst_out_valid", 32'(out_valid16), 32'd0);
        check("midrst_diff", 32'(diff16), 32'd0);
        check("midrst_flags", {30'd0, bout16, ovf16}, 32'd0);
        run_op(1'b0, 16'h0010, 16'h0001, 1'b0, 0, 1'b0);

        // Random 16-bit traffic
        for (int i = 0; i < 40; i++)
            run_op(1'b0, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                   $urandom_range(0, 3), 1'($urandom_range(0, 1)));

        // Exhaustive WIDTH=4
        for (int v = 0; v < 512; v++)
            run_op(1'b1, 16'(v & 15), 16'((v >> 4) & 15), 1'(v >> 8),
                   $urandom_range(0, 2), 1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_nibble_serial_sub
`default_nettype wire
